uart_fifo_ctrl: RTL and testbench
=================================

# uart_fifo_ctrl

Parametrised synchronous FIFO for the UART TX and RX data paths, succeeding the fixed-threshold buffer. Adds run-time programmable almost-full/almost-empty thresholds, a fill-level output, synchronous flush, sticky overflow/underflow error flags and an optional first-word-fall-through read mode. Sits between the baud-rate datapath (serializer/deserializer) and the host register interface, one instance per direction.

## Interface
- DATA_W, 8: word width in bits (≥1).
- DEPTH, 256: number of entries (≥2; power of two not required).
- CNT_W, $clog2(DEPTH+1): fill-count and threshold width (derived; not overridden).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock; release synchronised upstream.
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read/pop request.
- rd_data  out  DATA_W  read word.
- rd_valid  out  1  rd_data holds a newly popped word (standard mode) / head word present (FWFT mode).
- af_thr  in  CNT_W  almost-full threshold.
- ae_thr  in  CNT_W  almost-empty threshold.
- level  out  CNT_W  current entry count, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- overflow, underflow  out  1 each  sticky error flags.
- err_clr  in  1  clears sticky flags.

## Operation
- Accepted write: wr_en && !full. Accepted read: rd_en && !empty. Both judged on pre-edge state.
- Write while full: word dropped, overflow set; a simultaneous accepted read does not make room that cycle.
- Read while empty: no pointer change, underflow set; rd_data unchanged.
- Simultaneous accepted read and write: level unchanged, both pointers advance.
- Pointers: range 0..DEPTH-1, wrap DEPTH-1 → 0 for any DEPTH.
- level: +1 on write-only, −1 on read-only; never exceeds DEPTH or goes below 0.
- full = (level == DEPTH); empty = (level == 0); almost_full = (level ≥ af_thr); almost_empty = (level ≤ ae_thr). All combinational from level; thresholds sampled live.
- flush: pointers, level, overflow, underflow → 0 at next edge; overrides wr_en/rd_en same cycle; memory contents not cleared; rd_data retained.
- err_clr: clears overflow/underflow at next edge; a new error event in the same cycle wins (flag stays 1).
- Reset (rst_n low, asynchronous): level=0, pointers=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=(af_thr==0). Reset mid-burst discards all contents.

## Timing
- Standard mode: rd_data registered; word popped at edge N appears on rd_data after edge N, rd_valid=1 for exactly one cycle; rd_data holds until next pop.
- Write-to-read: word written at edge N is poppable from cycle after N (empty deasserts after N).
- Status flags and level update on the same edge as the pointer change; no extra latency.
- Full throughput: one write and one read per cycle sustained.

## Configuration
- UART_FIFO_FWFT_EN defined: first-word-fall-through; rd_data = mem[head] combinationally, rd_valid = !empty, rd_en acknowledges and pops current word; rd_data is don't-care while empty.
- Undefined: standard registered-read behaviour above.

## Structure
- Package uart_fifo_pkg: default DATA_W/DEPTH constants and a function returning CNT_W for a given DEPTH.
- Sub-module uart_fifo_mem: simple dual-port array (one write port, one read port, sync or async read selected by the FWFT macro); control, counters and flags stay in uart_fifo_ctrl.

## Test plan
- Reset then write 0x11,0x22,0x33, read 3 → rd_data 0x11,0x22,0x33 each one cycle after rd_en, rd_valid pulses, empty=1 at end, level=0.
- DEPTH=5: fill 5 words → full=1, level=5; 6th write → overflow=1, data dropped; read 5 then 5 more write/read pairs → correct order across wrap.
- af_thr=4, ae_thr=1: fill to 4 → almost_full rises at level 4; drain to 1 → almost_empty rises at level 1.
- Simultaneous wr_en/rd_en at level 3 → level stays 3, read data is oldest word; at level 0 → write accepted, read ignored, underflow=1.
- level 7, flush and wr_en same cycle → level 0, empty=1, overflow/underflow 0; err_clr coincident with rd_en on empty → underflow stays 1.
- rst_n asserted mid-transfer at level 4 → all outputs to reset values immediately; with UART_FIFO_FWFT_EN, first write 0xA5 → rd_data=0xA5, rd_valid=1 next cycle without rd_en.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared defaults and width helper
// for the UART TX/RX FIFO slice.
package uart_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;

  // fill count must represent 0..depth inclusive
  function automatic int cnt_w_f(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: 1W/1R storage array for the UART FIFO.
// Read is registered unless UART_FIFO_FWFT_EN is defined.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // storage is never cleared: flush and reset only move pointers
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

`ifdef UART_FIFO_FWFT_EN
  logic w_unused;
  assign w_unused = &{1'b0, rst_n, i_re};
  assign o_rdata  = r_mem[i_raddr];
`else
  logic [DATA_W-1:0] r_rdata;

  // popped word is captured and held until the next pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: pointers, fill level, flags, sticky errors.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads.
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = cnt_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [CNT_W-1:0]  af_thr,
  input  logic [CNT_W-1:0]  ae_thr,
  output logic [CNT_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_level;
  logic             r_ovf;
  logic             r_unf;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_ev;
  logic w_unf_ev;

  // wrap explicitly so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] f_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full   = (r_level == FULL_LVL);
  assign w_empty  = (r_level == '0);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_ovf_ev = wr_en & w_full;
  assign w_unf_ev = rd_en & w_empty;

  // pointer, level and sticky-error state; flush beats traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= f_inc(r_wptr);
      if (w_rd_acc) r_rptr <= f_inc(r_rptr);
      unique case (1'b1)
        (w_wr_acc & ~w_rd_acc): r_level <= r_level + 1'b1;
        (w_rd_acc & ~w_wr_acc): r_level <= r_level - 1'b1;
        default: ;
      endcase
      r_ovf <= (r_ovf & ~err_clr) | w_ovf_ev;
      r_unf <= (r_unf & ~err_clr) | w_unf_ev;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc & ~flush),
    .i_waddr (r_wptr),
    .i_wdata (wr_data),
    .i_re    (w_rd_acc & ~flush),
    .i_raddr (r_rptr),
    .o_rdata (rd_data)
  );

`ifdef UART_FIFO_FWFT_EN
  assign rd_valid = ~w_empty;
`else
  logic r_rd_valid;

  // one-cycle strobe marking a freshly popped word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_valid <= 1'b0;
    else if (flush) r_rd_valid <= 1'b0;
    else r_rd_valid <= w_rd_acc;
  end

  assign rd_valid = r_rd_valid;
`endif

  assign level        = r_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_level >= af_thr);
  assign almost_empty = (r_level <= ae_thr);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed bench with queue model
// for uart_fifo_ctrl (DEPTH=9, non-power-of-two).
module tb_uart_fifo_ctrl;

  localparam int DW = 8;
  localparam int DEPTH = 9;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic [CW-1:0] af_thr = CW'(4);
  logic [CW-1:0] ae_thr = CW'(1);
  logic [CW-1:0] level;
  logic full, empty, almost_full, almost_empty;
  logic overflow, underflow;
  logic err_clr = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  uart_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, got, exp, $time);
    end
  endtask

  // behavioural model: a queue of words plus sticky flags
  byte unsigned q[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  logic m_rv = 1'b0;
  logic [DW-1:0] m_rd = '0;
  int m_n;
  bit m_wa, m_ra;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd = '0;
      m_rv = 1'b0;
    end else if (flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv = 1'b0;
    end else begin
      m_n = q.size();
      m_wa = wr_en && (m_n < DEPTH);
      m_ra = rd_en && (m_n > 0);
      m_rv = m_ra;
      if (m_ra) m_rd = q.pop_front();
      if (m_wa) q.push_back(wr_data);
      m_ovf = (m_ovf && !err_clr) || (wr_en && m_n == DEPTH);
      m_unf = (m_unf && !err_clr) || (rd_en && m_n == 0);
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("level", 32'(level), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("almost_full", 32'(almost_full),
          32'(q.size() >= int'(af_thr)));
      chk("almost_empty", 32'(almost_empty),
          32'(q.size() <= int'(ae_thr)));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef UART_FIFO_FWFT_EN
      chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`else
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("rd_data", 32'(rd_data), 32'(m_rd));
`endif
    end
  end

  // one clock of traffic; returns 1 time unit after the edge
  task automatic cyc(input bit w, input logic [7:0] d,
                     input bit r);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst level", 32'(level), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst ae", 32'(almost_empty), 1);
    chk("rst af", 32'(almost_full), 0);
    chk("rst rd_valid", 32'(rd_valid), 0);
    rst_n = 1'b1;
    cyc(0, 8'h00, 0);

    // basic write three, read three
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(1, 8'h33, 0);
    chk("t1 level", 32'(level), 3);
    cyc(0, 8'h00, 1);
`ifndef UART_FIFO_FWFT_EN
    chk("t1 rd0", 32'(rd_data), 32'h11);
    chk("t1 rv0", 32'(rd_valid), 1);
`endif
    cyc(0, 8'h00, 1);
`ifndef UART_FIFO_FWFT_EN
    chk("t1 rd1", 32'(rd_data), 32'h22);
`endif
    cyc(0, 8'h00, 1);
`ifndef UART_FIFO_FWFT_EN
    chk("t1 rd2", 32'(rd_data), 32'h33);
`endif
    chk("t1 empty", 32'(empty), 1);
    cyc(0, 8'h00, 0);
`ifndef UART_FIFO_FWFT_EN
    chk("t1 rv drop", 32'(rd_valid), 0);
`endif

    // fill, overflow, drain, wrap with paired traffic
    for (int i = 1; i <= DEPTH; i++) cyc(1, 8'(i), 0);
    chk("t2 full", 32'(full), 1);
    chk("t2 level", 32'(level), 9);
    cyc(1, 8'hEE, 0);
    chk("t2 ovf", 32'(overflow), 1);
    chk("t2 level hold", 32'(level), 9);
    cyc(1, 8'hEF, 1);
    chk("t2 ovf full+rd", 32'(level), 8);
    cyc(1, 8'h0A, 0);
    err_clr = 1'b1;
    cyc(0, 8'h00, 0);
    err_clr = 1'b0;
    chk("t2 ovf clr", 32'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1);
    chk("t2 drained", 32'(level), 0);
    cyc(1, 8'h40, 0);
    for (int i = 1; i <= 10; i++) cyc(1, 8'(8'h40 + i), 1);
    chk("t2 pair level", 32'(level), 1);
    cyc(0, 8'h00, 1);
`ifndef UART_FIFO_FWFT_EN
    chk("t2 wrap rd", 32'(rd_data), 32'h4A);
`endif

    // thresholds af=4, ae=1
    cyc(1, 8'h50, 0);
    cyc(1, 8'h51, 0);
    cyc(1, 8'h52, 0);
    chk("t3 af at 3", 32'(almost_full), 0);
    cyc(1, 8'h53, 0);
    chk("t3 af at 4", 32'(almost_full), 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    chk("t3 ae at 2", 32'(almost_empty), 0);
    cyc(0, 8'h00, 1);
    chk("t3 ae at 1", 32'(almost_empty), 1);

    // simultaneous read/write at level 3 and at level 0
    cyc(1, 8'h54, 0);
    cyc(1, 8'h55, 0);
    cyc(1, 8'h56, 1);
    chk("t4 lvl3 pair", 32'(level), 3);
`ifndef UART_FIFO_FWFT_EN
    chk("t4 oldest", 32'(rd_data), 32'h53);
`endif
    repeat (3) cyc(0, 8'h00, 1);
    cyc(1, 8'h60, 1);
    chk("t4 lvl0 pair", 32'(level), 1);
    chk("t4 unf", 32'(underflow), 1);

    // err_clr vs new error, then flush with write
    cyc(0, 8'h00, 1);
    err_clr = 1'b1;
    cyc(0, 8'h00, 1);
    chk("t5 unf wins", 32'(underflow), 1);
    cyc(0, 8'h00, 0);
    err_clr = 1'b0;
    chk("t5 unf clr", 32'(underflow), 0);
    cyc(0, 8'h00, 1);
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'h70 + i), 0);
    chk("t5 level7", 32'(level), 7);
    flush = 1'b1;
    cyc(1, 8'h77, 0);
    flush = 1'b0;
    chk("t5 flush lvl", 32'(level), 0);
    chk("t5 flush empty", 32'(empty), 1);
    chk("t5 flush unf", 32'(underflow), 0);
    chk("t5 flush ovf", 32'(overflow), 0);
`ifndef UART_FIFO_FWFT_EN
    chk("t5 rd kept", 32'(rd_data), 32'h60);
`endif

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h80 + i), 0);
    chk("t6 level4", 32'(level), 4);
    wr_en = 1'b1;
    wr_data = 8'h84;
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst lvl", 32'(level), 0);
    chk("t6 rst empty", 32'(empty), 1);
    chk("t6 rst rv", 32'(rd_valid), 0);
`ifndef UART_FIFO_FWFT_EN
    chk("t6 rst rd", 32'(rd_data), 0);
`endif
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 8'h00, 0);

    // first word after reset
    cyc(1, 8'hA5, 0);
`ifdef UART_FIFO_FWFT_EN
    chk("t6 fwft rd", 32'(rd_data), 32'hA5);
    chk("t6 fwft rv", 32'(rd_valid), 1);
`else
    cyc(0, 8'h00, 1);
    chk("t6 rd", 32'(rd_data), 32'hA5);
    chk("t6 rv", 32'(rd_valid), 1);
`endif
    repeat (2) cyc(0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
